ksa_param: RTL and testbench
============================

// Module: ksa_param
// PURPOSE
//  Parametrised RC4-style key-scheduling engine with optional built-in S-box initialisation.
//  Drives one single-port synchronous RAM holding S[0..N-1], where N = 2**N_BITS.
//  - Optional init pass: writes S[k] = k for every k.
//  - KSA pass: for i = 0..N-1, j = (j + S[i] + key[i mod KEY_BYTES]) mod N, then swap S[i] and S[j].
//  Sits between the top-level controller (en/rdy handshake) and the S memory, ahead of the PRGA stage.
// PARAMETERS
//  N_BITS     8  address and data width; S-box depth N = 2**N_BITS
//  KEY_BYTES  3  number of key symbols, each N_BITS wide
// PORTS
//  clk      in   1                 clock
//  rst_n    in   1                 reset: one clock, synchronous, active-low
//  en       in   1                 start request; sampled only while rdy=1
//  init_en  in   1                 sampled with en; 1 = run the init pass before the KSA pass
//  rdy      out  1                 1 = idle and able to accept en
//  done     out  1                 one-cycle pulse when a run completes
//  key      in   KEY_BYTES*N_BITS  key symbol 0 = key[top N_BITS bits], symbol 1 = next lower, and so on
//  addr     out  N_BITS            RAM address
//  rddata   in   N_BITS            RAM read data, valid the cycle after addr is presented
//  wrdata   out  N_BITS            RAM write data
//  wren     out  1                 RAM write enable
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state <- IDLE; i, j and key index <- 0.
//   - Outputs: rdy=1, done=0, wren=0, addr=0, wrdata=0.
//   - Applies mid-run as well: the next cycle has wren=0; the partial S contents are left as they are.
//  Outputs are registered and change only on clk edges; no combinational paths from inputs to outputs.
//  IDLE: rdy=1, wren=0.
//   - en=1 latches key and init_en.
//   - Next state is INIT if init_en=1, else RD_I; rdy=0 in the following cycle.
//  INIT: one write per cycle, addr=k, wrdata=k, wren=1, for k = 0..N-1 (N cycles), then RD_I with i=0, j=0.
//  KSA iteration, 6 cycles per i:
//   - RD_I: addr=i, wren=0.
//   - CAP_I: capture si = rddata; j <= (j + si + key[kidx]) mod N, truncated to N_BITS.
//   - RD_J: addr=j (the new value).
//   - CAP_J: capture sj = rddata.
//   - WR_J: addr=j, wrdata=si, wren=1.
//   - WR_I: addr=i, wrdata=sj, wren=1.
//  Index rules:
//   - kidx is a wrapping counter 0..KEY_BYTES-1; no modulo divider.
//   - i increments after WR_I. If i was N-1, go to FIN; otherwise go to RD_I.
//  FIN: wren=0, done=1 for one cycle, then IDLE with rdy=1.
//  Latency from the en edge to done: (init_en ? N : 0) + 6N + 1 cycles.
//  Boundaries:
//   - i == j: both writes go to the same address with the same value; S is unchanged.
//   - en while rdy=0 is ignored.
//   - en held high through FIN starts a new run from the first IDLE cycle.
//   - key changes mid-run have no effect; key was latched at start.
//   - j wraps mod N; all arithmetic is N_BITS wide.
// TESTING
//  1 N_BITS=8, KEY_BYTES=3, key=0, init_en=1 -> 256 init writes k/k; then write pairs (0,0),(0,0), (1,1),(1,1), (3,2),(2,3); done after 1793 cycles.
//  2 N_BITS=4, KEY_BYTES=1, key=4'h5, init_en=1 -> final RAM matches software KSA model; done exactly 113 cycles after en.
//  3 N_BITS=8, key=24'h00033C, init_en=0 on a preloaded identity RAM -> first output is addr=0 read with no writes; final S matches model.
//  4 en pulsed mid-run and key changed mid-run -> no restart and no effect; result equals the clean run.
//  5 rst_n=0 during iteration i=100 -> next cycle rdy=1, wren=0, done=0; a new run then matches a clean run.
//  6 en held high continuously -> back-to-back runs; exactly one done pulse per run, one IDLE cycle between runs.

Source files
------------

// File: rtl/ksa_param.sv
// RC4-style key-scheduling engine driving a single-port synchronous S-box RAM,
// with an optional identity-fill pass ahead of the swap pass.
module ksa_param #(
  parameter int N_BITS    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          init_en,
  output logic                          rdy,
  output logic                          done,
  input  logic [KEY_BYTES*N_BITS-1:0]   key,
  output logic [N_BITS-1:0]             addr,
  input  logic [N_BITS-1:0]             rddata,
  output logic [N_BITS-1:0]             wrdata,
  output logic                          wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]     KLAST = KW'(KEY_BYTES - 1);
  localparam logic [N_BITS-1:0] ONE   = N_BITS'(1);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] INIT  = 4'd1;
  localparam logic [3:0] RD_I  = 4'd2;
  localparam logic [3:0] CAP_I = 4'd3;
  localparam logic [3:0] RD_J  = 4'd4;
  localparam logic [3:0] CAP_J = 4'd5;
  localparam logic [3:0] WR_J  = 4'd6;
  localparam logic [3:0] WR_I  = 4'd7;
  localparam logic [3:0] FIN   = 4'd8;

  logic [3:0]                        state;
  logic [N_BITS-1:0]                 i, j, si, sj;
  logic [N_BITS-1:0]                 i_nx, j_nx, key_sym;
  logic [KW-1:0]                     kidx;
  logic [KEY_BYTES*N_BITS-1:0]       key_q;

  // Symbol 0 sits in the most significant slice of the key.
  always_comb begin
    key_sym = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == KW'(b)) key_sym = key_q[(KEY_BYTES-1-b)*N_BITS +: N_BITS];
  end

  assign i_nx = i + ONE;
  assign j_nx = j + rddata + key_sym;

  // Outputs are set on the edge entering each state, so they are stable for that whole cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      sj     <= '0;
      kidx   <= '0;
      key_q  <= '0;
      rdy    <= 1'b1;
      done   <= 1'b0;
      wren   <= 1'b0;
      addr   <= '0;
      wrdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          wren <= 1'b0;
          if (en) begin
            key_q <= key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            rdy   <= 1'b0;
            addr  <= '0;
            if (init_en) begin
              state  <= INIT;
              wrdata <= '0;
              wren   <= 1'b1;
            end else begin
              state <= RD_I;
            end
          end
        end
        INIT: begin
          if (i == '1) begin
            i     <= '0;
            addr  <= '0;
            wren  <= 1'b0;
            state <= RD_I;
          end else begin
            i      <= i_nx;
            addr   <= i_nx;
            wrdata <= i_nx;
          end
        end
        RD_I: state <= CAP_I;
        CAP_I: begin
          si    <= rddata;
          j     <= j_nx;
          addr  <= j_nx;
          kidx  <= (kidx == KLAST) ? '0 : kidx + KW'(1);
          state <= RD_J;
        end
        RD_J: state <= CAP_J;
        CAP_J: begin
          sj     <= rddata;
          addr   <= j;
          wrdata <= si;
          wren   <= 1'b1;
          state  <= WR_J;
        end
        WR_J: begin
          addr   <= i;
          wrdata <= sj;
          state  <= WR_I;
        end
        WR_I: begin
          wren <= 1'b0;
          if (i == '1) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            i     <= i_nx;
            addr  <= i_nx;
            state <= RD_I;
          end
        end
        FIN: begin
          done  <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_param.sv
// Directed bench for ksa_param: an 8-bit/3-key instance and a 4-bit/1-key instance,
// each on its own behavioural synchronous RAM.
module tb_ksa_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // 8-bit instance
  logic        en8 = 1'b0, init8 = 1'b0;
  logic [23:0] key8 = '0;
  logic        rdy8, done8, wren8;
  logic [7:0]  addr8, rdd8, wrd8;
  logic [7:0]  mem8 [256];
  logic        fill8 = 1'b0, fgarb8 = 1'b0;

  // 4-bit instance
  logic        en4 = 1'b0, init4 = 1'b0;
  logic [3:0]  key4 = '0;
  logic        rdy4, done4, wren4;
  logic [3:0]  addr4, rdd4, wrd4;
  logic [3:0]  mem4 [16];
  logic        fill4 = 1'b0;

  logic [7:0]  exp8 [256];
  logic [7:0]  wa8 [$];
  logic [7:0]  wd8 [$];
  logic [7:0]  fa8;
  logic        fw8;

  ksa_param #(.N_BITS(8), .KEY_BYTES(3)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .init_en(init8), .rdy(rdy8), .done(done8),
    .key(key8), .addr(addr8), .rddata(rdd8), .wrdata(wrd8), .wren(wren8));

  ksa_param #(.N_BITS(4), .KEY_BYTES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .init_en(init4), .rdy(rdy4), .done(done4),
    .key(key4), .addr(addr4), .rddata(rdd4), .wrdata(wrd4), .wren(wren4));

  always @(posedge clk) begin
    if (fill8) begin
      for (int k = 0; k < 256; k++) mem8[k] <= fgarb8 ? 8'(k*37 + 11) : 8'(k);
    end else begin
      if (wren8) mem8[addr8] <= wrd8;
      rdd8 <= mem8[addr8];
    end
  end

  always @(posedge clk) begin
    if (fill4) begin
      for (int k = 0; k < 16; k++) mem4[k] <= 4'(k*7 + 3);
    end else begin
      if (wren4) mem4[addr4] <= wrd4;
      rdd4 <= mem4[addr4];
    end
  end

  task automatic fill_mem8(input logic garb);
    @(negedge clk); fill8 = 1'b1; fgarb8 = garb;
    @(negedge clk); fill8 = 1'b0;
  endtask

  // Software KSA over an identity S-box.
  task automatic model8(input logic [23:0] k);
    logic [7:0] jj, t, sym;
    for (int n = 0; n < 256; n++) exp8[n] = 8'(n);
    jj = '0;
    for (int n = 0; n < 256; n++) begin
      sym = k[(2 - n % 3)*8 +: 8];
      jj = jj + exp8[n] + sym;
      t = exp8[n]; exp8[n] = exp8[jj]; exp8[jj] = t;
    end
  endtask

  // Starts a run, records writes, returns the en-to-done latency (-1 on timeout).
  // At cycle 'poke' en is pulsed and the key is inverted.
  task automatic run8(input logic ini, input logic [23:0] k, input int poke, output int lat);
    wa8.delete(); wd8.delete();
    @(negedge clk); en8 = 1'b1; init8 = ini; key8 = k;
    @(negedge clk); en8 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 2000; c++) begin
      if (c == 1) begin fa8 = addr8; fw8 = wren8; end
      if (c == poke) begin en8 = 1'b1; key8 = ~k; end
      else if (c == poke + 1) en8 = 1'b0;
      if (wren8) begin wa8.push_back(addr8); wd8.push_back(wrd8); end
      if (done8) begin lat = c; break; end
      @(negedge clk);
    end
    en8 = 1'b0;
  endtask

  task automatic check_mem8(input string name);
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem8[k] !== exp8[k]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL %s: %0d S entries differ, want 0", name, bad);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({rdy8, done8, wren8, addr8, wrd8} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00})
      $display("FAIL reset8: got rdy/done/wren/addr/wrdata %b%b%b %h %h want 100 00 00",
               rdy8, done8, wren8, addr8, wrd8);
    else n_pass++;
    n_chk++;
    if ({rdy4, done4, wren4, addr4, wrd4} !== {1'b1, 1'b0, 1'b0, 4'h0, 4'h0})
      $display("FAIL reset4: got %b%b%b %h %h want 100 0 0", rdy4, done4, wren4, addr4, wrd4);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_init_key0;
    int lat, bad;
    int pa [6] = '{0, 0, 1, 1, 3, 2};
    int pd [6] = '{0, 0, 1, 1, 2, 3};
    fill_mem8(1'b1);
    run8(1'b1, 24'h0, 0, lat);
    n_chk++;
    if (lat !== 1793) $display("FAIL init_latency: got %0d want 1793", lat); else n_pass++;
    n_chk++;
    if (wa8.size() !== 768) $display("FAIL init_write_count: got %0d want 768", wa8.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 256 && k < wa8.size(); k++)
      if (int'(wa8[k]) != k || int'(wd8[k]) != k) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL init_writes: %0d bad k/k writes, want 0", bad); else n_pass++;
    for (int p = 0; p < 6; p++) begin
      n_chk++;
      if (256 + p >= wa8.size() || int'(wa8[256+p]) !== pa[p] || int'(wd8[256+p]) !== pd[p])
        $display("FAIL swap_write_%0d: got (%0d,%0d) want (%0d,%0d)", p,
                 (256 + p < wa8.size()) ? int'(wa8[256+p]) : -1,
                 (256 + p < wd8.size()) ? int'(wd8[256+p]) : -1, pa[p], pd[p]);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if ({rdy8, done8} !== 2'b10) $display("FAIL post_done: got rdy/done %b%b want 10", rdy8, done8);
    else n_pass++;
    model8(24'h0);
    check_mem8("init_key0_final");
  endtask

  task automatic test_n4;
    int lat = -1;
    int bad = 0;
    int exp4 [16] = '{1, 12, 7, 13, 0, 8, 14, 15, 10, 2, 3, 5, 11, 6, 4, 9};
    @(negedge clk); fill4 = 1'b1;
    @(negedge clk); fill4 = 1'b0; en4 = 1'b1; init4 = 1'b1; key4 = 4'h5;
    @(negedge clk); en4 = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (done4) begin lat = c; break; end
      @(negedge clk);
    end
    n_chk++;
    if (lat !== 113) $display("FAIL n4_latency: got %0d want 113", lat); else n_pass++;
    @(negedge clk);
    for (int k = 0; k < 16; k++) if (int'(mem4[k]) != exp4[k]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL n4_final: %0d S entries differ, want 0", bad); else n_pass++;
    n_chk++;
    if (rdy4 !== 1'b1) $display("FAIL n4_rdy: got %b want 1", rdy4); else n_pass++;
  endtask

  task automatic test_no_init;
    int lat;
    fill_mem8(1'b0);
    run8(1'b0, 24'h00033C, 0, lat);
    n_chk++;
    if ({fa8, fw8} !== {8'h00, 1'b0}) $display("FAIL noinit_first: got addr %h wren %b want 00 0", fa8, fw8);
    else n_pass++;
    n_chk++;
    if (lat !== 1537) $display("FAIL noinit_latency: got %0d want 1537", lat); else n_pass++;
    n_chk++;
    if (wa8.size() !== 512) $display("FAIL noinit_write_count: got %0d want 512", wa8.size());
    else n_pass++;
    @(negedge clk);
    model8(24'h00033C);
    check_mem8("noinit_final");
  endtask

  task automatic test_mid_run_inputs;
    int lat;
    fill_mem8(1'b1);
    run8(1'b1, 24'h1A2B3C, 500, lat);
    n_chk++;
    if (lat !== 1793) $display("FAIL midrun_latency: got %0d want 1793", lat); else n_pass++;
    @(negedge clk);
    model8(24'h1A2B3C);
    check_mem8("midrun_final");
  endtask

  task automatic test_reset_mid_run;
    int lat;
    fill_mem8(1'b1);
    @(negedge clk); en8 = 1'b1; init8 = 1'b1; key8 = 24'h1A2B3C;
    @(negedge clk); en8 = 1'b0;
    repeat (860) @(negedge clk);
    n_chk++;
    if ({wren8, addr8} !== {1'b1, 8'(8'h1A + 8'h00)} && wren8 !== 1'b1)
      $display("FAIL midrun_wrj: got wren %b want 1", wren8);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rdy8, wren8, done8} !== 3'b100)
      $display("FAIL midrun_reset: got rdy/wren/done %b%b%b want 100", rdy8, wren8, done8);
    else n_pass++;
    rst_n = 1'b1;
    fill_mem8(1'b1);
    run8(1'b1, 24'h1A2B3C, 0, lat);
    n_chk++;
    if (lat !== 1793) $display("FAIL after_reset_latency: got %0d want 1793", lat); else n_pass++;
    @(negedge clk);
    check_mem8("after_reset_final");
  endtask

  task automatic test_back_to_back;
    int ndone = 0, nrdy = 0, d1 = -1, d2 = -1;
    logic fin = 1'b0;
    @(negedge clk); en8 = 1'b1; init8 = 1'b0; key8 = 24'h123456;
    for (int c = 1; c <= 3100; c++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      if (rdy8) nrdy++;
    end
    n_chk++;
    if (ndone !== 2) $display("FAIL b2b_done_count: got %0d want 2", ndone); else n_pass++;
    n_chk++;
    if (d1 !== 1537 || d2 !== 3075) $display("FAIL b2b_done_cycles: got %0d,%0d want 1537,3075", d1, d2);
    else n_pass++;
    n_chk++;
    if (nrdy !== 2) $display("FAIL b2b_idle_cycles: got %0d want 2", nrdy); else n_pass++;
    en8 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rdy8) begin fin = 1'b1; break; end
    end
    n_chk++;
    if (fin !== 1'b1) $display("FAIL b2b_drain: got rdy %b want 1 within bound", rdy8); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_key0();
    test_n4();
    test_no_init();
    test_mid_run_inputs();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
